// File: rtl/timer_ctrl.sv
// Interval timer: modulo-PRE prescaler feeding a down-counting period register,
// sequenced by an IDLE/RUN/PAUSE/DONE state machine with one-shot and periodic modes.
module timer_ctrl #(
    parameter int PRE      = 8,
    parameter int PRE_BITS = 3,
    parameter int W        = 8
) (
    input  logic         clk,
    input  logic         r_n,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic         mode,
    input  logic [W-1:0] period,
    output logic         tick,
    output logic         done,
    output logic [W-1:0] remain,
    output logic         busy,
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [PRE_BITS-1:0] pre_q, pre_d;
    logic [W-1:0]        remain_q, remain_d;
    logic                m_q, m_d;
    logic                tick_q, tick_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                load_ok;
    logic                wrap;

    function automatic logic [W-1:0] sat_dec(input logic [W-1:0] v);
        return (v == '0) ? v : v - W'(1);
    endfunction

    assign load_ok = start && (period != '0);
    assign wrap    = (pre_q == PRE_BITS'(PRE - 1));

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        remain_d = remain_q;
        m_d      = m_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;

        if (stop) begin
            state_d  = S_IDLE;
            pre_d    = '0;
            remain_d = '0;
        end else if (load_ok) begin
            state_d  = S_RUN;
            pre_d    = '0;
            remain_d = period;
            m_d      = mode;
        end else begin
            case (state_q)
                S_RUN, S_PAUSE: begin
                    // The PAUSE exit edge counts like a RUN edge, so no edge is lost.
                    if (pause) begin
                        state_d = S_PAUSE;
                    end else begin
                        state_d = S_RUN;
                        if (wrap) begin
                            pre_d  = '0;
                            tick_d = 1'b1;
                            if (remain_q == W'(1)) begin
                                done_d = 1'b1;
                                if (!m_q || (period == '0)) begin
                                    state_d  = S_DONE;
                                    remain_d = '0;
                                end else begin
                                    remain_d = period;
                                    m_d      = mode;
                                end
                            end else begin
                                remain_d = sat_dec(remain_q);
                            end
                        end else begin
                            pre_d = pre_q + PRE_BITS'(1);
                        end
                    end
                end
                S_DONE: remain_d = '0;
                default: ;
            endcase
        end

        busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
    end

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            state_q  <= S_IDLE;
            pre_q    <= '0;
            remain_q <= '0;
            m_q      <= 1'b0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            remain_q <= remain_d;
            m_q      <= m_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign tick   = tick_q;
    assign done   = done_q;
    assign remain = remain_q;
    assign busy   = busy_q;
    assign state  = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: one-shot, periodic, pause, priority, zero period, async reset.
module tb_timer_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         r_n;
    logic         start;
    logic         stop;
    logic         pause;
    logic         mode;
    logic [W-1:0] period;
    logic         tick;
    logic         done;
    logic [W-1:0] remain;
    logic         busy;
    logic [1:0]   state;

    int n_assert = 0;
    int n_fail   = 0;

    timer_ctrl #(.PRE(8), .PRE_BITS(3), .W(W)) dut (
        .clk    (clk),
        .r_n    (r_n),
        .start  (start),
        .stop   (stop),
        .pause  (pause),
        .mode   (mode),
        .period (period),
        .tick   (tick),
        .done   (done),
        .remain (remain),
        .busy   (busy),
        .state  (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse(input logic [W-1:0] p, input logic md);
        period = p;
        mode   = md;
        start  = 1'b1;
        edge_();
        start  = 1'b0;
    endtask

    initial begin
        r_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0; period = '0;
        #2;
        chk("rst_state", state, 2'b00);
        chk("rst_busy", busy, 0);
        chk("rst_tick", tick, 0);
        chk("rst_done", done, 0);
        chk("rst_remain", remain, 0);
        @(negedge clk);
        r_n = 1'b1;

        // One-shot, period 3
        start_pulse(3, 1'b0);
        chk("os_busy0", busy, 1);
        chk("os_state0", state, 2'b01);
        chk("os_remain0", remain, 3);
        for (int e = 1; e <= 24; e++) begin
            edge_();
            chk($sformatf("os_tick@%0d", e), tick, (e % 8 == 0));
            chk($sformatf("os_remain@%0d", e), remain, 3 - e / 8);
            chk($sformatf("os_done@%0d", e), done, (e == 24));
        end
        chk("os_state_done", state, 2'b11);
        chk("os_busy_done", busy, 0);
        edge_();
        chk("os_hold_state", state, 2'b11);
        chk("os_hold_done", done, 0);

        // Periodic, period 2
        start_pulse(2, 1'b1);
        for (int e = 1; e <= 40; e++) begin
            edge_();
            chk($sformatf("per_tick@%0d", e), tick, (e % 8 == 0));
            chk($sformatf("per_done@%0d", e), done, (e == 16 || e == 32));
            chk($sformatf("per_remain@%0d", e), remain, ((e / 8) % 2 == 0) ? 2 : 1);
            chk($sformatf("per_state@%0d", e), state, 2'b01);
        end
        stop = 1'b1;
        edge_();
        stop = 1'b0;
        chk("stop_state", state, 2'b00);
        chk("stop_remain", remain, 0);
        chk("stop_busy", busy, 0);

        // Pause for edges 5..9
        start_pulse(2, 1'b0);
        for (int e = 1; e <= 21; e++) begin
            pause = (e >= 5 && e <= 9);
            edge_();
            chk($sformatf("pz_tick@%0d", e), tick, (e == 13 || e == 21));
            chk($sformatf("pz_done@%0d", e), done, (e == 21));
            chk($sformatf("pz_remain@%0d", e), remain, (e < 13) ? 2 : ((e < 21) ? 1 : 0));
            chk($sformatf("pz_state@%0d", e), state,
                (e == 21) ? 2'b11 : ((e >= 5 && e <= 9) ? 2'b10 : 2'b01));
            chk($sformatf("pz_busy@%0d", e), busy, (e != 21));
        end
        pause = 1'b0;

        // Stop and start together on the wrap edge
        start_pulse(2, 1'b0);
        for (int e = 1; e <= 7; e++) edge_();
        stop = 1'b1; start = 1'b1;
        edge_();
        stop = 1'b0; start = 1'b0;
        chk("pri_ss_state", state, 2'b00);
        chk("pri_ss_remain", remain, 0);
        chk("pri_ss_tick", tick, 0);
        chk("pri_ss_done", done, 0);

        // Start alone on the wrap edge restarts the interval
        start_pulse(5, 1'b0);
        for (int e = 1; e <= 7; e++) edge_();
        period = 4; start = 1'b1;
        edge_();
        start = 1'b0;
        chk("pri_s_remain", remain, 4);
        chk("pri_s_tick", tick, 0);
        chk("pri_s_state", state, 2'b01);
        for (int e = 9; e <= 16; e++) begin
            edge_();
            chk($sformatf("pri_s_tick@%0d", e), tick, (e == 16));
            chk($sformatf("pri_s_remain@%0d", e), remain, (e == 16) ? 3 : 4);
        end

        // Zero period start is ignored
        stop = 1'b1;
        edge_();
        stop = 1'b0;
        start_pulse(0, 1'b0);
        chk("zp_state", state, 2'b00);
        chk("zp_busy", busy, 0);
        for (int e = 1; e <= 8; e++) begin
            edge_();
            chk($sformatf("zp_tick@%0d", e), tick, 0);
        end

        // Periodic reload seeing period 0 ends in DONE
        start_pulse(1, 1'b1);
        for (int e = 1; e <= 8; e++) edge_();
        chk("zr_done1", done, 1);
        chk("zr_state1", state, 2'b01);
        chk("zr_remain1", remain, 1);
        period = 0;
        for (int e = 9; e <= 16; e++) edge_();
        chk("zr_done2", done, 1);
        chk("zr_tick2", tick, 1);
        chk("zr_state2", state, 2'b11);
        chk("zr_remain2", remain, 0);
        chk("zr_busy2", busy, 0);

        // Asynchronous reset while RUN, just after a tick
        start_pulse(3, 1'b0);
        for (int e = 1; e <= 8; e++) edge_();
        chk("ar_tick_pre", tick, 1);
        chk("ar_remain_pre", remain, 2);
        #2;
        r_n = 1'b0;
        #1;
        chk("ar_state", state, 2'b00);
        chk("ar_busy", busy, 0);
        chk("ar_tick", tick, 0);
        chk("ar_done", done, 0);
        chk("ar_remain", remain, 0);
        @(negedge clk);
        r_n = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            edge_();
            chk($sformatf("ar_idle_tick@%0d", e), tick, 0);
            chk($sformatf("ar_idle_state@%0d", e), state, 2'b00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
